// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the execute stage and the pipeline control unit.
// The master side raises requests; the slave (pipe_ctrl) returns strobes.
interface pipe_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             jump_en_i;
  logic [XLEN-1:0]  jump_addr_i;
  logic             hold_flag_i;
  logic             ext_stall_i;
  logic             pc_jump_en_o;
  logic [XLEN-1:0]  pc_jump_addr_o;
  logic             hold_pc_o;
  logic             hold_if_id_o;
  logic             hold_id_ex_o;
  logic             flush_if_id_o;
  logic             flush_id_ex_o;
  logic             busy_o;
  logic [CNT_W-1:0] redirect_cnt_o;

  modport master (
    output jump_en_i, jump_addr_i, hold_flag_i, ext_stall_i,
    input  pc_jump_en_o, pc_jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
           flush_if_id_o, flush_id_ex_o, busy_o, redirect_cnt_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i, hold_flag_i, ext_stall_i,
    output pc_jump_en_o, pc_jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
           flush_if_id_o, flush_id_ex_o, busy_o, redirect_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: PC redirect, hold and flush strobes, fixed flush window
// after each redirect, and a jump parked across an external stall.
module pipe_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, FLUSH, STALL} state_t;

  state_t           state, ret_state, eff_state;
  logic [FC_W-1:0]  cnt;
  logic             pend_valid;
  logic [XLEN-1:0]  pend_addr;
  logic [CNT_W-1:0] redirect_cnt;

  logic             release_pend, redirect, hold, flush_if, flush_ex;
  logic [XLEN-1:0]  redirect_addr;

  // Leaving STALL without a parked jump behaves as the saved state would this cycle.
  always_comb begin
    eff_state     = state;
    release_pend  = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    hold          = 1'b0;
    flush_if      = 1'b0;
    flush_ex      = 1'b0;
    if (state == STALL && !bus.ext_stall_i) begin
      if (pend_valid) release_pend = 1'b1;
      else            eff_state    = ret_state;
    end
    if (bus.ext_stall_i) begin
      hold = 1'b1;
    end else if (release_pend) begin
      redirect      = 1'b1;
      redirect_addr = pend_addr;
      flush_if      = 1'b1;
      flush_ex      = 1'b1;
    end else if (eff_state == IDLE && bus.jump_en_i) begin
      redirect      = 1'b1;
      redirect_addr = bus.jump_addr_i;
      flush_if      = 1'b1;
      flush_ex      = 1'b1;
    end else if (eff_state == IDLE && bus.hold_flag_i) begin
      hold = 1'b1;
    end else if (eff_state == FLUSH) begin
      flush_if = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ret_state    <= IDLE;
      cnt          <= '0;
      pend_valid   <= 1'b0;
      pend_addr    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (redirect) redirect_cnt <= redirect_cnt + 1'b1;
      if (bus.ext_stall_i) begin
        if (state != STALL) begin
          ret_state <= state;
          state     <= STALL;
          if (state == IDLE && bus.jump_en_i) begin
            pend_valid <= 1'b1;
            pend_addr  <= bus.jump_addr_i;
          end
        end else if (!pend_valid && ret_state == IDLE && bus.jump_en_i) begin
          pend_valid <= 1'b1;
          pend_addr  <= bus.jump_addr_i;
        end
      end else if (redirect) begin
        if (release_pend) pend_valid <= 1'b0;
        if (FLUSH_CYCLES > 1) begin
          state <= FLUSH;
          cnt   <= FC_W'(FLUSH_CYCLES - 1);
        end else begin
          state <= IDLE;
        end
      end else if (eff_state == FLUSH) begin
        if (cnt <= FC_W'(1)) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          state <= FLUSH;
          cnt   <= cnt - 1'b1;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

  // Combinational strobes are forced low for the whole time reset is held.
  assign bus.pc_jump_en_o   = redirect & ~rst;
  assign bus.pc_jump_addr_o = rst ? '0 : redirect_addr;
  assign bus.hold_pc_o      = hold & ~rst;
  assign bus.hold_if_id_o   = hold & ~rst;
  assign bus.hold_id_ex_o   = hold & ~rst;
  assign bus.flush_if_id_o  = flush_if & ~rst;
  assign bus.flush_id_ex_o  = flush_ex & ~rst;
  assign bus.busy_o         = (state != IDLE) | pend_valid;
  assign bus.redirect_cnt_o = redirect_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: expected output vectors are queued as
// stimulus is applied and popped when the outputs are sampled mid-cycle.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.XLEN(32), .CNT_W(32)) w ();
  pipe_ctrl_if #(.XLEN(32), .CNT_W(4))  w4 ();

  pipe_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(w));
  // Narrow-counter twin sees identical stimulus so counter wrap is reachable.
  pipe_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(w4));

  assign w4.jump_en_i   = w.jump_en_i;
  assign w4.jump_addr_i = w.jump_addr_i;
  assign w4.hold_flag_i = w.hold_flag_i;
  assign w4.ext_stall_i = w.ext_stall_i;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic        hpc, hif, hex;
    logic        fif, fex;
    logic        busy;
    logic [31:0] rcnt;
  } obs_t;

  obs_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_cnt = 0;

  function automatic obs_t mk(logic en, logic [31:0] addr, logic hold, logic fif,
                              logic fex, logic busy, logic [31:0] rcnt);
    obs_t o;
    o.en = en; o.addr = en ? addr : 32'h0;
    o.hpc = hold; o.hif = hold; o.hex = hold;
    o.fif = fif; o.fex = fex; o.busy = busy; o.rcnt = rcnt;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.en = w.pc_jump_en_o; o.addr = w.pc_jump_en_o ? w.pc_jump_addr_o : 32'h0;
    o.hpc = w.hold_pc_o; o.hif = w.hold_if_id_o; o.hex = w.hold_id_ex_o;
    o.fif = w.flush_if_id_o; o.fex = w.flush_id_ex_o;
    o.busy = w.busy_o; o.rcnt = w.redirect_cnt_o;
    return o;
  endfunction

  task automatic drive(logic j, logic [31:0] a, logic h, logic s);
    w.jump_en_i = j; w.jump_addr_i = a; w.hold_flag_i = h; w.ext_stall_i = s;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    drive(1, 32'hDEAD_BEEF, 1, 0);
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_held got=%h exp=%h", got, exp); end
    tick();
    drive(0, 0, 0, 0); rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      @(negedge clk); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_idle c%0d got=%h exp=%h", c, got, exp); end
      tick();
    end
  endtask

  // Redirect, one flush-only cycle, then idle; hold_flag_i during FLUSH must be ignored.
  task automatic test_jump(logic [31:0] addr, logic hold_with_jump, logic hold_in_flush);
    obs_t got, exp;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin drive(1, addr, hold_with_jump, 0); sb.push_back(mk(1, addr, 0, 1, 1, 0, exp_cnt)); end
        1: begin drive(0, 0, hold_in_flush, 0); sb.push_back(mk(0, 0, 0, 1, 0, 1, exp_cnt + 1)); end
        default: begin drive(0, 0, 0, 0); sb.push_back(mk(0, 0, 0, 0, 0, 0, exp_cnt + 1)); end
      endcase
      @(negedge clk); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL jump_%h c%0d got=%h exp=%h", addr, c, got, exp); end
      tick();
    end
    exp_cnt++;
  endtask

  task automatic test_hold();
    obs_t got, exp;
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, c < 3, 0);
      sb.push_back(mk(0, 0, c < 3, 0, 0, 0, exp_cnt));
      @(negedge clk); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL hold c%0d got=%h exp=%h", c, got, exp); end
      tick();
    end
  endtask

  task automatic test_stall_jump();
    obs_t got, exp;
    for (int c = 0; c < 7; c++) begin
      case (c)
        0:       begin drive(0, 0, 0, 1);         sb.push_back(mk(0, 0, 1, 0, 0, 0, exp_cnt)); end
        1:       begin drive(1, 32'h100, 0, 1);   sb.push_back(mk(0, 0, 1, 0, 0, 1, exp_cnt)); end
        2, 3:    begin drive(0, 0, 0, 1);         sb.push_back(mk(0, 0, 1, 0, 0, 1, exp_cnt)); end
        4:       begin drive(1, 32'h999, 0, 0);   sb.push_back(mk(1, 32'h100, 0, 1, 1, 1, exp_cnt)); end
        5:       begin drive(0, 0, 0, 0);         sb.push_back(mk(0, 0, 0, 1, 0, 1, exp_cnt + 1)); end
        default: begin drive(0, 0, 0, 0);         sb.push_back(mk(0, 0, 0, 0, 0, 0, exp_cnt + 1)); end
      endcase
      @(negedge clk); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_jump c%0d got=%h exp=%h", c, got, exp); end
      tick();
    end
    exp_cnt++;
  endtask

  // A stall landing inside the flush window freezes it; the window resumes after release.
  task automatic test_stall_in_flush();
    obs_t got, exp;
    for (int c = 0; c < 5; c++) begin
      case (c)
        0:       begin drive(1, 32'h44, 0, 0); sb.push_back(mk(1, 32'h44, 0, 1, 1, 0, exp_cnt)); end
        1, 2:    begin drive(1, 32'h88, 0, 1); sb.push_back(mk(0, 0, 1, 0, 0, 1, exp_cnt + 1)); end
        3:       begin drive(0, 0, 0, 0);      sb.push_back(mk(0, 0, 0, 1, 0, 1, exp_cnt + 1)); end
        default: begin drive(0, 0, 0, 0);      sb.push_back(mk(0, 0, 0, 0, 0, 0, exp_cnt + 1)); end
      endcase
      @(negedge clk); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_in_flush c%0d got=%h exp=%h", c, got, exp); end
      tick();
    end
    exp_cnt++;
  endtask

  task automatic test_reset_abort();
    obs_t got, exp;
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: begin drive(1, 32'h44, 0, 0); sb.push_back(mk(1, 32'h44, 0, 1, 1, 0, exp_cnt)); end
        1: begin rst = 1'b1; drive(1, 32'h48, 1, 0); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0)); exp_cnt = 0; end
        2: begin rst = 1'b0; drive(0, 0, 0, 0); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0)); end
        3: begin drive(1, 32'h200, 0, 1); sb.push_back(mk(0, 0, 1, 0, 0, 0, 0)); end
        4: begin drive(0, 0, 0, 1); sb.push_back(mk(0, 0, 1, 0, 0, 1, 0)); end
        5: begin rst = 1'b1; sb.push_back(mk(0, 0, 0, 0, 0, 0, 0)); end
        default: begin rst = 1'b0; drive(0, 0, 0, 0); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0)); end
      endcase
      @(negedge clk); got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_abort c%0d got=%h exp=%h", c, got, exp); end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [3:0]  exp4;
    logic [31:0] got32;
    for (int n = 1; n <= 16; n++) begin
      drive(1, 32'h1000 + n, 0, 0); tick();
      drive(0, 0, 0, 0); tick();
      exp4 = 4'(n);
      exp_cnt++;
      @(negedge clk); checks++;
      if (w4.redirect_cnt_o !== exp4) begin
        errors++; $display("FAIL wrap4 n%0d got=%h exp=%h", n, w4.redirect_cnt_o, exp4);
      end
      got32 = w.redirect_cnt_o; checks++;
      if (got32 !== exp_cnt) begin errors++; $display("FAIL cnt32 n%0d got=%h exp=%h", n, got32, exp_cnt); end
      tick();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_jump(32'h8000_0040, 1'b0, 1'b1);
    test_hold();
    test_stall_jump();
    test_jump(32'h0000_1234, 1'b1, 1'b0);
    test_stall_in_flush();
    test_reset_abort();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
